// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial word feeder for the serial sequence detectors.
// Latency: first bit of a word accepted from idle appears on w one cycle after the accept edge.
// Backpressure: din_ready drops while the one-word hold buffer is full and rises after it reloads.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] hbuf, hbuf_nxt;
  logic             hvalid, hvalid_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sh_shifted;

  // Ready depends only on registered state (and reset), never on din_valid.
  assign din_ready = !rst && !hvalid;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);

  // Move the shifter one position toward the output end, zero filling behind.
  assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  // State register and datapath storage; reset discards in-flight and buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      hbuf   <= '0;
      hvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      cnt    <= cnt_nxt;
      hbuf   <= hbuf_nxt;
      hvalid <= hvalid_nxt;
    end
  end

  // Next-state logic: load, shift, reload from buffer, bypass, or return to idle.
  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    cnt_nxt    = cnt;
    hbuf_nxt   = hbuf;
    hvalid_nxt = hvalid;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_nxt    = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Buffered word has priority; while it is held din_ready is low, so
          // an accept can never coincide with the reload.
          if (hvalid) begin
            sh_nxt     = hbuf;
            hvalid_nxt = 1'b0;
            cnt_nxt    = '0;
          end else if (accept) begin
            // Bypass straight into the shifter so the buffer is never touched.
            sh_nxt  = din;
            cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
            sh_nxt    = '0;
            cnt_nxt   = '0;
          end
        end else begin
          sh_nxt  = sh_shifted;
          cnt_nxt = cnt + CW'(1);
          if (accept) begin
            hbuf_nxt   = din;
            hvalid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: w is forced low while idle so the detector sits in reset.
  always_comb begin
    w_valid    = (state == SHIFT);
    w          = 1'b0;
    if (w_valid) begin
      w = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    end
    frame_done = last_bit;
    busy       = (state == SHIFT) || hvalid;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial stage that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `w`. It feeds the `w` input of the serial sequence-detector FSMs in this design. A one-word holding buffer lets consecutive words stream with no idle gap between them. When idle, `w` is held at 0, which parks the downstream detector in its reset state.

## Interface
- `WIDTH`, 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  WIDTH  parallel word, sampled on accept.
- `din_valid`  in  1  upstream has a word on `din`.
- `din_ready`  out  1  block can accept a word this cycle.
- `w`  out  1  serial data bit to the detector.
- `w_valid`  out  1  `w` carries a data bit this cycle.
- `frame_done`  out  1  current `w` bit is the last bit of its word.
- `busy`  out  1  block holds any unsent data (shifter or buffer).

## Operation
- Accept happens at a rising edge where `din_valid && din_ready` are both high. The word is then committed; it is never dropped except by reset.
- Storage:
  - shift register `sh[WIDTH-1:0]`;
  - bit counter `cnt` (0..WIDTH-1);
  - hold register `hbuf` with flag `hvalid`.
- State machine, two states:
  - IDLE:
    - `w_valid`=0, `w`=0, `frame_done`=0; `hvalid` is always 0 here.
    - On accept: `sh`←`din`, `cnt`←0, go to SHIFT.
  - SHIFT:
    - `w_valid`=1.
    - `w` = `sh[WIDTH-1]` if MSB_FIRST=1, else `sh[0]`.
    - Each edge: shift `sh` by one toward the output end (zero fill) and increment `cnt`.
    - At the edge where `cnt`==WIDTH-1, the first matching rule below applies:
      - `hvalid`=1: `sh`←`hbuf`, `hvalid`←0, `cnt`←0, stay in SHIFT.
      - `hvalid`=0 and an accept occurs on this edge: `sh`←`din` (bypass), `cnt`←0, stay in SHIFT.
      - Otherwise: go to IDLE.
    - An accept while `cnt`≠WIDTH-1: `hbuf`←`din`, `hvalid`←1.
- `din_ready` = !`rst` && !`hvalid`. It is combinational from registered state and does not depend on `din_valid`.
- `frame_done` = `w_valid` && (`cnt`==WIDTH-1). It is combinational and high for exactly one cycle per word.
- `busy` = (state==SHIFT) || `hvalid`.
- Consecutive words produce contiguous `w_valid` with no gap cycle. The bit order is preserved within each word and across words.
- `din` is ignored in any cycle without an accept.

## Timing
- Reset: any edge with `rst`=1 sets:
  - state IDLE, `cnt`=0, `sh`=0, `hvalid`=0;
  - outputs `w`=0, `w_valid`=0, `frame_done`=0, `busy`=0;
  - `din_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- Latency: a word accepted at edge k from IDLE drives its first bit on `w` during cycle k+1. The last bit is on `w` during cycle k+WIDTH, with `frame_done`=1 in that cycle.
- With no follow-on word, `w_valid` falls and `w`=0 from cycle k+WIDTH+1.
- Throughput: one bit per clock sustained. `din_ready` falls the cycle after the buffer fills. It rises in the cycle after the reload edge.
- Simultaneous events:
  - An accept on the last-bit edge with the buffer empty takes the bypass path; no buffer write occurs.
  - With the buffer full, `din_ready`=0, so no accept can coincide with the reload.
- Reset mid-word: the word in flight and any buffered word are discarded. `frame_done` is not asserted for the aborted word. `w` returns to 0 from the cycle after the reset edge.
- `rst` has priority over every other event on the same edge.

## Test plan
- Reset, WIDTH=8, MSB_FIRST=1; accept 8'hB2 at edge k -> `w`=1,0,1,1,0,0,1,0 in cycles k+1..k+8; `frame_done` only in k+8; `w_valid`=0, `w`=0 at k+9; `busy` low at k+9.
- `din_valid` held high with 8'hF0 then 8'h0F -> 16 contiguous valid bits 1111000000001111. `din_ready`=0 from cycle k+2 until the reload edge k+8, then 1. Two `frame_done` pulses, 8 cycles apart.
- Backpressure: third word 8'hAA presented while `din_ready`=0, `din_valid` held -> accepted on the first edge with `din_ready`=1; its bits follow 8'h0F with no gap and none are lost.
- MSB_FIRST=0, accept 8'h01 -> `w`=1,0,0,0,0,0,0,0; then send 8'h80 with an idle gap -> `w`=0,0,0,0,0,0,0,1.
- Assert `rst` for one edge while the third bit of 8'hFF is on `w` and the buffer holds 8'h55:
  - next cycle: `w_valid`=0, `w`=0, `busy`=0, no `frame_done`;
  - after release: `din_ready`=1, and a fresh 8'h81 serializes correctly with no 8'h55 bits.
- Bypass: `din_valid` rises with 8'hC3 exactly in the `frame_done` cycle of the previous word, buffer empty -> C3 bits start the very next cycle and `hvalid` stays 0.
